// File: rtl/sentinel_attempt_guard_if.sv
// Bundle of the key/submit inputs and the guard status outputs shared between
// the attempt guard and whatever drives it (board glue, comparator, bench).
interface sentinel_attempt_guard_if;
    logic       ena;
    logic [7:0] key_raw;
    logic       submit_raw;
    logic       match;
    logic [7:0] key_q;
    logic       key_valid;
    logic       unlocked;
    logic       locked_out;
    logic [1:0] fail_count;
    logic [1:0] state;

    modport master (
        output ena, key_raw, submit_raw, match,
        input  key_q, key_valid, unlocked, locked_out, fail_count, state
    );

    modport slave (
        input  ena, key_raw, submit_raw, match,
        output key_q, key_valid, unlocked, locked_out, fail_count, state
    );
endinterface

// File: rtl/sentinel_attempt_guard.sv
// Keypad attempt guard: synchronizes and debounces a DIP key and submit button,
// checks submitted keys against an external comparator and locks out after repeated failures.
module sentinel_attempt_guard #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int MAX_FAILS       = 3,
    parameter int LOCKOUT_CYCLES  = 1024
) (
    input logic                      clk,
    input logic                      rst_n,
    sentinel_attempt_guard_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CHECK    = 2'd1,
        UNLOCKED = 2'd2,
        LOCKOUT  = 2'd3
    } state_t;

    localparam int                   CNT_W      = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0]     DEB_MAX    = CNT_W'(DEBOUNCE_CYCLES);
    localparam int                   TIMER_W    = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
    localparam logic [TIMER_W-1:0]   TIMER_LOAD = TIMER_W'(LOCKOUT_CYCLES - 1);
    localparam logic [1:0]           FAIL_LIMIT = 2'(MAX_FAILS);

    logic [7:0]         key_sync1, key_sync2, key_prev, key_stable;
    logic               sub_sync1, sub_sync2, sub_prev, sub_stable, sub_stable_d;
    logic [CNT_W-1:0]   key_cnt, sub_cnt;
    logic               submit_pulse;

    state_t             state_q, state_d;
    logic [7:0]         key_q_r, key_q_d;
    logic [1:0]         fail_q, fail_d;
    logic [TIMER_W-1:0] timer_q, timer_d;

    // Stable copies only load once the value has also matched on the current cycle,
    // so the first edge after a long quiet period cannot slip through a saturated counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            key_sync1    <= '0;
            key_sync2    <= '0;
            key_prev     <= '0;
            key_stable   <= '0;
            key_cnt      <= '0;
            sub_sync1    <= 1'b0;
            sub_sync2    <= 1'b0;
            sub_prev     <= 1'b0;
            sub_stable   <= 1'b0;
            sub_stable_d <= 1'b0;
            sub_cnt      <= '0;
        end else if (bus.ena) begin
            key_sync1 <= bus.key_raw;
            key_sync2 <= key_sync1;
            key_prev  <= key_sync2;
            if (key_sync2 != key_prev)
                key_cnt <= '0;
            else if (key_cnt != DEB_MAX)
                key_cnt <= key_cnt + 1'b1;
            if (key_cnt == DEB_MAX && key_sync2 == key_prev)
                key_stable <= key_sync2;

            sub_sync1 <= bus.submit_raw;
            sub_sync2 <= sub_sync1;
            sub_prev  <= sub_sync2;
            if (sub_sync2 != sub_prev)
                sub_cnt <= '0;
            else if (sub_cnt != DEB_MAX)
                sub_cnt <= sub_cnt + 1'b1;
            if (sub_cnt == DEB_MAX && sub_sync2 == sub_prev)
                sub_stable <= sub_sync2;
            sub_stable_d <= sub_stable;
        end
    end

    assign submit_pulse = sub_stable & ~sub_stable_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            key_q_r <= '0;
            fail_q  <= '0;
            timer_q <= '0;
        end else if (bus.ena) begin
            state_q <= state_d;
            key_q_r <= key_q_d;
            fail_q  <= fail_d;
            timer_q <= timer_d;
        end
    end

    // Submit pulses outside IDLE fall through the defaults and are simply lost.
    always_comb begin
        state_d = state_q;
        key_q_d = key_q_r;
        fail_d  = fail_q;
        timer_d = timer_q;
        case (state_q)
            IDLE: begin
                if (submit_pulse) begin
                    key_q_d = key_stable;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (bus.match) begin
                    fail_d  = '0;
                    state_d = UNLOCKED;
                end else begin
                    fail_d = fail_q + 2'd1;
                    if (fail_q + 2'd1 == FAIL_LIMIT) begin
                        state_d = LOCKOUT;
                        timer_d = TIMER_LOAD;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            UNLOCKED: begin
                if (key_stable != key_q_r)
                    state_d = IDLE;
            end
            LOCKOUT: begin
                if (timer_q == '0) begin
                    state_d = IDLE;
                    fail_d  = '0;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.key_q      = key_q_r;
    assign bus.key_valid  = (state_q == CHECK);
    assign bus.unlocked   = (state_q == UNLOCKED);
    assign bus.locked_out = (state_q == LOCKOUT);
    assign bus.fail_count = fail_q;
    assign bus.state      = state_q;

endmodule

// File: tb/tb_sentinel_attempt_guard.sv
// Directed bench for the attempt guard: correct key, lockout timing, bounce rejection,
// dropped submits, enable freeze and reset recovery, with a comparator that accepts 0xB6.
module tb_sentinel_attempt_guard;

    logic       clk;
    logic       rst_n;
    int         checks = 0;
    int         errors = 0;
    int         tcount = 0;
    int         valid_cycles;
    logic [7:0] key_seen;
    int         len, entries, fail_bad;
    int         nvalid, first_valid, final_edge;

    sentinel_attempt_guard_if bus();

    sentinel_attempt_guard dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    assign bus.match = (bus.key_q == 8'hB6);

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
        tcount += n;
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic press_submit(input int hold, output int vc, output logic [7:0] ks);
        vc = 0;
        ks = 8'h00;
        bus.submit_raw = 1'b1;
        for (int i = 0; i < hold + 30; i++) begin
            if (i == hold) bus.submit_raw = 1'b0;
            tick(1);
            if (bus.key_valid === 1'b1) begin
                vc++;
                ks = bus.key_q;
            end
        end
    endtask

    task automatic wait_state(input logic [1:0] s, input int budget, input string tag);
        for (int i = 0; i < budget && bus.state !== s; i++) tick(1);
        check_output(tag, bus.state, s);
    endtask

    // Counts LOCKOUT cycles starting at the first observed one; presses submit midway.
    task automatic run_lockout(input int freeze_at, input int reset_at,
                               output int l, output int ent, output int fb);
        l   = 1;
        ent = 0;
        fb  = 0;
        while (bus.locked_out === 1'b1 && l < 3000) begin
            if (l == 40)  bus.submit_raw = 1'b0;
            if (l == 100) bus.submit_raw = 1'b1;
            if (l == 200) bus.submit_raw = 1'b0;
            if (l == freeze_at)       bus.ena = 1'b0;
            if (l == freeze_at + 100) bus.ena = 1'b1;
            if (l == reset_at)        rst_n = 1'b0;
            tick(1);
            if (bus.key_valid === 1'b1) ent++;
            if (bus.locked_out === 1'b1 && bus.fail_count !== 2'd3) fb++;
            if (bus.locked_out === 1'b1) l++;
        end
    endtask

    initial begin
        rst_n          = 1'b0;
        bus.ena        = 1'b1;
        bus.key_raw    = 8'h00;
        bus.submit_raw = 1'b0;
        tick(3);
        check_output("rst_state", bus.state, 2'd0);
        check_output("rst_key_q", bus.key_q, 8'h00);
        check_output("rst_key_valid", bus.key_valid, 1'b0);
        check_output("rst_unlocked", bus.unlocked, 1'b0);
        check_output("rst_locked_out", bus.locked_out, 1'b0);
        check_output("rst_fail_count", bus.fail_count, 2'd0);
        rst_n = 1'b1;

        // Correct key unlocks
        bus.key_raw = 8'hB6;
        tick(25);
        press_submit(40, valid_cycles, key_seen);
        check_output("ok_valid_cycles", valid_cycles, 1);
        check_output("ok_key_at_check", key_seen, 8'hB6);
        check_output("ok_key_q", bus.key_q, 8'hB6);
        check_output("ok_unlocked", bus.unlocked, 1'b1);
        check_output("ok_state", bus.state, 2'd2);
        check_output("ok_fail_count", bus.fail_count, 2'd0);

        // Submit while unlocked is dropped
        press_submit(40, valid_cycles, key_seen);
        check_output("unl_submit_valid", valid_cycles, 0);
        check_output("unl_submit_state", bus.state, 2'd2);
        check_output("unl_submit_fail", bus.fail_count, 2'd0);

        // Key change leaves UNLOCKED only after debounce
        bus.key_raw = 8'hB7;
        tick(10);
        check_output("unl_hold_state", bus.state, 2'd2);
        wait_state(2'd0, 40, "unl_exit_state");
        check_output("unl_exit_fail", bus.fail_count, 2'd0);
        check_output("unl_exit_unlocked", bus.unlocked, 1'b0);

        // Three wrong submits reach lockout
        bus.key_raw = 8'h00;
        tick(25);
        press_submit(40, valid_cycles, key_seen);
        check_output("f1_valid", valid_cycles, 1);
        check_output("f1_key", key_seen, 8'h00);
        check_output("f1_fail", bus.fail_count, 2'd1);
        check_output("f1_state", bus.state, 2'd0);
        press_submit(40, valid_cycles, key_seen);
        check_output("f2_fail", bus.fail_count, 2'd2);
        bus.submit_raw = 1'b1;
        wait_state(2'd3, 40, "f3_enter_lockout");
        check_output("f3_locked_out", bus.locked_out, 1'b1);
        run_lockout(-1, -1, len, entries, fail_bad);
        check_output("lock_len", len, 1024);
        check_output("lock_check_entries", entries, 0);
        check_output("lock_fail_held", fail_bad, 0);
        check_output("lock_exit_state", bus.state, 2'd0);
        check_output("lock_exit_fail", bus.fail_count, 2'd0);

        // Bouncing submit yields one late pulse
        nvalid      = 0;
        first_valid = -1;
        final_edge  = 0;
        for (int i = 0; i < 50; i++) begin
            if (i % 3 == 0) begin
                bus.submit_raw = ~bus.submit_raw;
                if (bus.submit_raw) final_edge = tcount;
            end
            tick(1);
            if (bus.key_valid === 1'b1) nvalid++;
        end
        for (int i = 0; i < 90; i++) begin
            if (i == 60) bus.submit_raw = 1'b0;
            tick(1);
            if (bus.key_valid === 1'b1) begin
                nvalid++;
                if (first_valid < 0) first_valid = tcount;
            end
        end
        check_output("bounce_pulses", nvalid, 1);
        check_output("bounce_delay_ok", ((first_valid - final_edge) >= 18), 1'b1);
        check_output("bounce_fail", bus.fail_count, 2'd1);

        // Enable freeze stretches the lockout by 100 cycles
        press_submit(40, valid_cycles, key_seen);
        check_output("fz_pre_fail", bus.fail_count, 2'd2);
        bus.submit_raw = 1'b1;
        wait_state(2'd3, 40, "fz_enter_lockout");
        run_lockout(300, -1, len, entries, fail_bad);
        check_output("fz_len", len, 1124);
        check_output("fz_check_entries", entries, 0);
        check_output("fz_fail_held", fail_bad, 0);
        check_output("fz_exit_state", bus.state, 2'd0);
        check_output("fz_exit_fail", bus.fail_count, 2'd0);

        // Reset in the middle of lockout
        press_submit(40, valid_cycles, key_seen);
        press_submit(40, valid_cycles, key_seen);
        check_output("rl_pre_fail", bus.fail_count, 2'd2);
        bus.submit_raw = 1'b1;
        wait_state(2'd3, 40, "rl_enter_lockout");
        run_lockout(-1, 524, len, entries, fail_bad);
        check_output("rl_len", len, 524);
        check_output("rl_state", bus.state, 2'd0);
        check_output("rl_locked_out", bus.locked_out, 1'b0);
        check_output("rl_fail", bus.fail_count, 2'd0);
        rst_n = 1'b1;

        // Reset while unlocked, submit held through release
        bus.key_raw = 8'hB6;
        tick(25);
        press_submit(40, valid_cycles, key_seen);
        check_output("ru_pre_unlocked", bus.unlocked, 1'b1);
        bus.submit_raw = 1'b1;
        tick(5);
        rst_n = 1'b0;
        tick(1);
        check_output("ru_state", bus.state, 2'd0);
        check_output("ru_unlocked", bus.unlocked, 1'b0);
        check_output("ru_key_q", bus.key_q, 8'h00);
        rst_n  = 1'b1;
        nvalid = 0;
        for (int i = 0; i < 80; i++) begin
            tick(1);
            if (bus.key_valid === 1'b1) nvalid++;
        end
        check_output("ru_held_pulses", nvalid, 1);
        check_output("ru_relock_unlocked", bus.unlocked, 1'b1);
        bus.submit_raw = 1'b0;
        tick(30);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sentinel_attempt_guard.md
SENTINEL_ATTEMPT_GUARD -- requirements
Module: sentinel_attempt_guard

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 16: consecutive stable synchronized cycles required before an input is accepted.
REQ-002 SHALL have parameter MAX_FAILS, default 3, legal range 1..3: failed submissions that trigger lockout.
REQ-003 SHALL have parameter LOCKOUT_CYCLES, default 1024, minimum 1: cycles spent in LOCKOUT.
REQ-004 SHALL have port clk, input, 1: the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n, input, 1: reset, synchronous and active-low.
REQ-006 SHALL have port ena, input, 1: design enable.
REQ-007 SHALL have port key_raw, input, 8: raw DIP-switch key, asynchronous.
REQ-008 SHALL have port submit_raw, input, 1: raw submit pushbutton, asynchronous, active-high.
REQ-009 SHALL have port match, input, 1: downstream comparator result for key_q, combinational, valid the same cycle.
REQ-010 SHALL have port key_q, output, 8: latched candidate key driven to the comparator.
REQ-011 SHALL have port key_valid, output, 1: high exactly while in CHECK.
REQ-012 SHALL have port unlocked, output, 1: high exactly while in UNLOCKED.
REQ-013 SHALL have port locked_out, output, 1: high exactly while in LOCKOUT.
REQ-014 SHALL have port fail_count, output, 2: current consecutive-failure count.
REQ-015 SHALL have port state, output, 2: FSM state, encoded IDLE=0, CHECK=1, UNLOCKED=2, LOCKOUT=3.

Function
REQ-016 SHALL, while ena=0, freeze every register, including synchronizers, counters and FSM; outputs hold their values.
REQ-017 SHALL pass key_raw and submit_raw each through a two-flop synchronizer before any other use.
REQ-018 SHALL debounce each synchronized signal with its own counter: reset to 0 when the value differs from the previous cycle, else increment saturating at DEBOUNCE_CYCLES; the stable copy loads the synchronized value when the counter equals DEBOUNCE_CYCLES.
REQ-019 SHALL generate submit_pulse for exactly one cycle on a 0->1 transition of debounced submit; holding the button produces one pulse only.
REQ-020 SHALL, in IDLE on submit_pulse, load key_q with the debounced key and move to CHECK; otherwise stay in IDLE.
REQ-021 SHALL spend exactly one cycle in CHECK, sampling match in that cycle; key_q SHALL not change during CHECK even if the debounced key changes.
REQ-022 SHALL, in CHECK with match=1, clear fail_count and go to UNLOCKED.
REQ-023 SHALL, in CHECK with match=0, increment fail_count; if the new count equals MAX_FAILS, go to LOCKOUT and load the timer with LOCKOUT_CYCLES-1; otherwise go to IDLE.
REQ-024 SHALL stay in UNLOCKED until the debounced key differs from key_q, then go to IDLE with fail_count unchanged at 0.
REQ-025 SHALL, in LOCKOUT, decrement the timer each cycle; at timer=0, go to IDLE and clear fail_count, so LOCKOUT lasts exactly LOCKOUT_CYCLES cycles.
REQ-026 SHALL drop submit_pulse in CHECK, UNLOCKED and LOCKOUT; drops are never queued or counted.
REQ-027 SHALL never let fail_count exceed MAX_FAILS; with MAX_FAILS=1, the first failure enters LOCKOUT directly.
REQ-028 SHALL compute every output from registers only, except that the CHECK-cycle decision uses match.

Reset
REQ-029 SHALL, when rst_n=0 at a rising clk edge, regardless of ena, set: state IDLE; key_q 0x00; key_valid 0; unlocked 0; locked_out 0; fail_count 0; timer 0; synchronizers, debounce counters and stable copies 0.
REQ-030 SHALL return to IDLE with fail_count 0 when reset is asserted mid-LOCKOUT or mid-UNLOCKED; no state survives reset.
REQ-031 SHALL, if submit_raw is held high through reset release, emit one submit_pulse after debounce.

Verification
REQ-032 Bench SHALL cover correct key: key_raw=0xB6 stable, submit pressed 40 cycles, match=1 when key_q=0xB6 -> key_q=0xB6, key_valid high 1 cycle, then unlocked=1, fail_count=0.
REQ-033 Bench SHALL cover lockout: 3 submits of 0x00 with match=0 -> fail_count 1, 2, then locked_out=1 for exactly 1024 cycles, then IDLE with fail_count=0.
REQ-034 Bench SHALL cover bounce: submit_raw toggling every 3 cycles for 50 cycles, then held high -> exactly one key_valid pulse, no earlier than 2+DEBOUNCE_CYCLES cycles after the final edge.
REQ-035 Bench SHALL cover submits during lockout and unlock: submit pressed in LOCKOUT and in UNLOCKED -> no CHECK entry, fail_count unchanged; key_raw 0xB6->0xB7 while UNLOCKED -> IDLE after debounce.
REQ-036 Bench SHALL cover reset mid-LOCKOUT: rst_n=0 for 1 cycle at timer~500 -> next cycle state=0, locked_out=0, fail_count=0.
REQ-037 Bench SHALL cover ena=0: ena=0 for 100 cycles in LOCKOUT -> timer and outputs frozen; the lockout completes 100 cycles later than nominal.
